// File: rtl/key_step_if.sv
// key_step_if: button input, repeat enable and debounced key/step/held outputs
interface key_step_if;
  logic key_in;
  logic rep_en;
  logic key_lvl;
  logic step;
  logic held;
  modport master (output key_in, rep_en, input key_lvl, step, held);
  modport slave (input key_in, rep_en, output key_lvl, step, held);
endinterface

// File: rtl/key_step.sv
// key_step: push-button debouncer with single-cycle step strobe and hold-to-repeat
module key_step #(
  parameter int DEB_CYCLES = 20000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input logic Clk,
  input logic Rst,
  key_step_if.slave bus
);
  localparam int DW   = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam int RMAX = REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX);
  localparam logic [DW-1:0] DEB_TC = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DLY_TC = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PER_TC = RW'(REP_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_t;
  state_t state;
  logic s1, key_s;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge Clk)
    if (Rst) {key_s, s1} <= 2'b00;
    else {key_s, s1} <= {s1, bus.key_in};
  // level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge Clk)
    if (Rst) begin
      bus.key_lvl <= 1'b0;
      dcnt <= '0;
    end else if (key_s == bus.key_lvl) begin
      dcnt <= '0;
    end else if (dcnt == DEB_TC) begin
      bus.key_lvl <= key_s;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  // press/repeat FSM; release beats rep_en drop beats terminal count
  always_ff @(posedge Clk)
    if (Rst) begin
      state <= IDLE;
      rcnt <= '0;
      bus.step <= 1'b0;
      bus.held <= 1'b0;
    end else begin
      bus.step <= 1'b0;
      case (state)
        IDLE:
          if (bus.key_lvl) begin
            bus.step <= 1'b1;
            bus.held <= 1'b1;
            rcnt <= '0;
            state <= bus.rep_en ? DELAY : HOLD;
          end else bus.held <= 1'b0;
        HOLD:
          if (!bus.key_lvl) begin
            state <= IDLE;
            bus.held <= 1'b0;
          end
        default:
          if (!bus.key_lvl) begin
            state <= IDLE;
            bus.held <= 1'b0;
          end else if (!bus.rep_en) state <= HOLD;
          else if (rcnt == (state == DELAY ? DLY_TC : PER_TC)) begin
            bus.step <= 1'b1;
            rcnt <= '0;
            state <= REPEAT;
          end else rcnt <= rcnt + RW'(1);
      endcase
    end
endmodule

// File: tb/tb_key_step.sv
// tb_key_step: directed checks of debounce, step timing, repeat, cancel and reset
module tb_key_step;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int steps[$];
  logic prev_step = 1'b0;
  logic seen = 1'b0;
  int p, q, r, f;
  int rep_off[11] = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34, 37};
  int rst_off[4] = '{0, 10, 13, 16};
  key_step_if bus();
  key_step #(.DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.slave)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (bus.step) steps.push_back(cyc);
    chk("step_wide", bus.step & prev_step, 0);
    prev_step = bus.step;
    seen = seen | bus.key_lvl | bus.step | bus.held;
  endtask
  task automatic wait_step(output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.step) begin
        at = cyc;
        return;
      end
    end
    chk("step_timeout", bus.step, 1);
  endtask
  initial begin
    bus.key_in = 1'b0;
    bus.rep_en = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    chk("rst_lvl", bus.key_lvl, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_held", bus.held, 0);
    steps.delete();
    bus.key_in = 1'b1;
    repeat (5) tick();
    chk("clean_lvl5", bus.key_lvl, 0);
    tick();
    chk("clean_lvl6", bus.key_lvl, 1);
    chk("clean_step6", bus.step, 0);
    chk("clean_held6", bus.held, 0);
    tick();
    chk("clean_step7", bus.step, 1);
    chk("clean_held7", bus.held, 1);
    tick();
    chk("clean_step8", bus.step, 0);
    chk("clean_held8", bus.held, 1);
    repeat (22) tick();
    bus.key_in = 1'b0;
    repeat (5) tick();
    chk("rel_lvl5", bus.key_lvl, 1);
    tick();
    chk("rel_lvl6", bus.key_lvl, 0);
    chk("rel_held6", bus.held, 1);
    tick();
    chk("rel_held7", bus.held, 0);
    chk("clean_nsteps", steps.size(), 1);
    repeat (5) tick();
    seen = 1'b0;
    bus.key_in = 1'b1;
    repeat (3) tick();
    bus.key_in = 1'b0;
    repeat (12) tick();
    chk("glitch_quiet", seen, 0);
    steps.delete();
    for (int i = 0; i < 3; i++) begin
      bus.key_in = 1'b1;
      tick();
      tick();
      bus.key_in = 1'b0;
      tick();
      tick();
    end
    bus.key_in = 1'b1;
    f = cyc + 1;
    repeat (20) tick();
    chk("bounce_nsteps", steps.size(), 1);
    chk("bounce_at", steps[0], f + 6);
    bus.key_in = 1'b0;
    repeat (15) tick();
    bus.rep_en = 1'b1;
    steps.delete();
    bus.key_in = 1'b1;
    wait_step(p);
    repeat (33) tick();
    bus.key_in = 1'b0;
    repeat (6) tick();
    chk("rep_held39", bus.held, 1);
    tick();
    chk("rep_held40", bus.held, 0);
    chk("rep_step40", bus.step, 0);
    repeat (10) tick();
    chk("rep_nsteps", steps.size(), 11);
    for (int i = 0; i < 11; i++) chk($sformatf("rep_off%0d", i), steps[i] - p, rep_off[i]);
    steps.delete();
    bus.key_in = 1'b1;
    wait_step(p);
    repeat (13) tick();
    bus.rep_en = 1'b0;
    repeat (20) tick();
    chk("cancel_held", bus.held, 1);
    bus.key_in = 1'b0;
    repeat (6) tick();
    chk("cancel_lvl", bus.key_lvl, 0);
    chk("cancel_held6", bus.held, 1);
    tick();
    chk("cancel_held7", bus.held, 0);
    chk("cancel_nsteps", steps.size(), 3);
    chk("cancel_last", steps[2] - p, 13);
    repeat (5) tick();
    bus.rep_en = 1'b1;
    steps.delete();
    bus.key_in = 1'b1;
    wait_step(p);
    repeat (11) tick();
    Rst = 1'b1;
    tick();
    chk("mrst_lvl", bus.key_lvl, 0);
    chk("mrst_step", bus.step, 0);
    chk("mrst_held", bus.held, 0);
    tick();
    Rst = 1'b0;
    r = cyc;
    steps.delete();
    wait_step(q);
    chk("mrst_lat", q - r, 7);
    repeat (16) tick();
    chk("mrst_nsteps", steps.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("mrst_off%0d", i), steps[i] - q, rst_off[i]);
    bus.key_in = 1'b0;
    repeat (15) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_step.md
# key_step

Debounce and step-pulse generator for a raw push-button. Sits directly upstream of the 8-bit shift-register stage. Converts a bouncing, asynchronous key into two outputs: a clean debounced level, which drives the shifter's serial-in `key` bit, and a single-cycle `step` strobe, which drives the shifter's update enable. An optional hold-to-repeat mode emits further `step` pulses while the key stays pressed.

## Interface
- `DEB_CYCLES`, default 20000: number of consecutive cycles a synchronized input must disagree with `key_lvl` before `key_lvl` flips. Minimum 1.
- `REP_DELAY`, default 25000000: cycles from the first `step` to the first auto-repeat `step`. Minimum 2.
- `REP_PERIOD`, default 5000000: cycles between successive auto-repeat `step` pulses. Minimum 2.
- `Clk`  input  1  single system clock; all logic on the rising edge.
- `Rst`  input  1  synchronous, active-high reset.
- `key_in`  input  1  raw button, active-high, asynchronous to `Clk`.
- `rep_en`  input  1  auto-repeat enable, synchronous to `Clk`.
- `key_lvl`  output  1  debounced key level (registered).
- `step`  output  1  one-cycle strobe per accepted press or repeat (registered).
- `held`  output  1  high while the FSM is in any state other than IDLE (registered).

## Operation
- **Synchronizer.** `key_in` passes through two flops; the second flop's output is `key_s`.
- **Debounce counter.** `dcnt` is `$clog2(DEB_CYCLES)` bits, minimum 1. On each edge:
  - If `key_s == key_lvl`: `dcnt <= 0`.
  - Else if `dcnt == DEB_CYCLES-1`: `key_lvl <= key_s` and `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - Any single cycle of agreement restarts the count.
- **FSM states:** IDLE, HOLD, DELAY, REPEAT. The repeat counter `rcnt` is sized for `max(REP_DELAY, REP_PERIOD)`.
- **IDLE**
  - On `key_lvl==1`: set `step<=1` and `rcnt<=0`.
  - Go to DELAY if `rep_en==1`, else go to HOLD.
- **HOLD**
  - No pulses.
  - On `key_lvl==0`: go to IDLE.
- **DELAY**
  - On `key_lvl==0`: go to IDLE.
  - Else if `rep_en==0`: go to HOLD.
  - Else if `rcnt==REP_DELAY-1`: set `step<=1`, `rcnt<=0`, go to REPEAT.
  - Else: `rcnt<=rcnt+1`.
- **REPEAT**
  - Same as DELAY, but the terminal count is `REP_PERIOD-1` and the state stays REPEAT.
- **Priority** within a cycle: release (`key_lvl==0`), then `rep_en==0`, then terminal count. A release on the same edge as a terminal count produces no `step`.
- `step` defaults to 0 on every edge where it is not explicitly set. It is never high for two consecutive cycles.
- `held` is registered and equals `(next_state != IDLE)`.
- **Reset values:** `key_lvl=0`, `step=0`, `held=0`, synchronizer flops=0, `dcnt=0`, `rcnt=0`, state IDLE.
- **Reset mid-operation:** all outputs are 0 on the edge after `Rst` is sampled high. If the key is still pressed after `Rst` falls, it is debounced afresh and counted as a new press (one `step`).

## Timing
- Edge numbering: edge 1 is the first edge that samples `key_in` high (stable thereafter).
  - `key_s` is high after edge 2.
  - `key_lvl` is high after edge `DEB_CYCLES+2`.
  - `step` is high for the one cycle after edge `DEB_CYCLES+3`; `held` rises on the same edge.
- Release is symmetric: `key_lvl` falls `DEB_CYCLES+2` edges after the first low sample, and `held` falls one edge later.
- With `rep_en=1` and the first `step` in cycle P, further pulses occur in cycles P+REP_DELAY, P+REP_DELAY+REP_PERIOD, P+REP_DELAY+2·REP_PERIOD, and so on.
- Glitches shorter than `DEB_CYCLES` cycles, after synchronization, never change `key_lvl`.
- End-to-end latency from clean press to `step` is `DEB_CYCLES+3` cycles.

## Test plan
All scenarios use `DEB_CYCLES=4`, `REP_DELAY=10`, `REP_PERIOD=3`.
- **Clean press, no repeat.** `rep_en=0`; `key_in` high from edge 1 for 30 cycles, then low.
  - `key_lvl` high after edge 6.
  - `step` high only in the cycle after edge 7; `held` high from edge 7.
  - After release, `key_lvl` low after 6 edges and `held` low 1 edge later.
  - Exactly 1 `step` in total.
- **Glitch rejection.** `key_in` high for 3 cycles, then low.
  - `key_lvl`, `step` and `held` stay 0 throughout.
- **Bounce.** `key_in` toggles every 2 cycles for 12 cycles, then stays high for 20 cycles.
  - Exactly one `step`, 7 cycles after the final rising sample.
- **Auto-repeat.** `rep_en=1`; key held 40 cycles after first `step` at cycle P.
  - `step` at P, P+10, P+13, P+16, …, P+37: 11 pulses, each 1 cycle wide.
- **Repeat cancel.** `rep_en` drops to 0 at P+14 while the key is held.
  - No `step` after P+13.
  - `held` stays 1 until the release is debounced.
- **Reset mid-repeat.** Assert `Rst` for 2 cycles at P+12 with the key held.
  - All outputs are 0 the edge after `Rst` is sampled.
  - After `Rst` falls, a new `step` appears 7 cycles later; repeat restarts from that `step`.
